// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and IMEM.
interface fetch_stage_if #(
  parameter int DATA_W = 32
);
  logic              IMem_Req;
  logic [DATA_W-1:0] IMem_Addr;
  logic              IMem_Ready;
  logic [DATA_W-1:0] IMem_Instr;

  modport master (
    output IMem_Req,
    output IMem_Addr,
    input  IMem_Ready,
    input  IMem_Instr
  );

  modport slave (
    input  IMem_Req,
    input  IMem_Addr,
    output IMem_Ready,
    output IMem_Instr
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IMEM request FSM with one-entry skid buffer,
// and the IF/ID pipeline register with bubble/hold/flush control.
module fetch_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  fetch_stage_if.master     imem,
  input  logic              PCWrite,
  input  logic              IFID_Write,
  input  logic              Flush,
  input  logic [DATA_W-1:0] Branch_Target,
  output logic [DATA_W-1:0] Instr_ID,
  output logic [DATA_W-1:0] PC_ID,
  output logic              Valid_ID,
  output logic              Fetch_Busy
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction

  state_t            state_p0, state_d;
  logic [DATA_W-1:0] pc_p0, pc_d;
  logic [DATA_W-1:0] stale_p0, stale_d;
  logic [DATA_W-1:0] skid_p0, skid_d;

  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc_p1;
  logic              vld_p1;
  logic              busy_p1;

  logic              available;
  logic              advance;
  logic              bubble;
  logic [DATA_W-1:0] instr_avail;

  // Next-state, next-PC, skid-buffer and IMEM request decode
  always_comb begin
    state_d        = state_p0;
    pc_d           = pc_p0;
    stale_d        = stale_p0;
    skid_d         = skid_p0;
    imem.IMem_Req  = 1'b1;
    imem.IMem_Addr = pc_p0;

    available   = ((state_p0 == FETCH) && imem.IMem_Ready) || (state_p0 == HOLD);
    instr_avail = (state_p0 == HOLD) ? skid_p0 : imem.IMem_Instr;
    advance     = available && PCWrite && IFID_Write && !Flush;
    bubble      = !available && IFID_Write && !Flush;

    // DROP keeps presenting the abandoned address until memory answers it
    if (state_p0 == HOLD) imem.IMem_Req = 1'b0;
    if (state_p0 == DROP) imem.IMem_Addr = stale_p0;

    if (Flush) begin
      pc_d   = word_align(Branch_Target);
      skid_d = '0;
      case (state_p0)
        FETCH: begin
          if (imem.IMem_Ready) begin
            state_d = FETCH;
          end else begin
            state_d = DROP;
            stale_d = pc_p0;
          end
        end
        HOLD:    state_d = FETCH;
        DROP:    state_d = DROP;
        default: state_d = FETCH;
      endcase
    end else if (advance) begin
      pc_d    = pc_inc(pc_p0);
      state_d = FETCH;
    end else begin
      case (state_p0)
        FETCH: begin
          if (imem.IMem_Ready) begin
            skid_d  = imem.IMem_Instr;
            state_d = HOLD;
          end
        end
        HOLD: state_d = HOLD;
        DROP: begin
          if (imem.IMem_Ready) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // Fetch control state: FSM, PC, stale address and skid buffer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0 <= FETCH;
      pc_p0    <= '0;
      stale_p0 <= '0;
      skid_p0  <= '0;
    end else begin
      state_p0 <= state_d;
      pc_p0    <= pc_d;
      stale_p0 <= stale_d;
      skid_p0  <= skid_d;
    end
  end

  // ---- IF/ID boundary ----
  // IF/ID register: flush and bubble clear it, advance loads it, otherwise hold
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_p1 <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      busy_p1  <= 1'b0;
    end else begin
      busy_p1 <= bubble;
      if (Flush || bubble) begin
        instr_p1 <= '0;
        vld_p1   <= 1'b0;
      end else if (advance) begin
        instr_p1 <= instr_avail;
        pc_p1    <= pc_inc(pc_p0);
        vld_p1   <= 1'b1;
      end
    end
  end

  assign Instr_ID   = instr_p1;
  assign PC_ID      = pc_p1;
  assign Valid_ID   = vld_p1;
  assign Fetch_Busy = busy_p1;

endmodule
